// File: rtl/trap_ctrl.sv
// trap_ctrl: machine-mode trap controller for the milano core.
//
// It arbitrates synchronous exceptions (illegal, ecall, ebreak) and enabled
// interrupts (MEI, MSI, MTI, plus NUM_LOCAL_IRQ platform lines on mip/mie
// bits 16 and up) for the instruction in ex. A taken trap runs a fixed CSR
// save sequence (mcause, mepc, mtval, mstatus), then redirects fetch to the
// mtvec target. MRET restores mstatus and jumps to mepc in a single cycle.
//
// Handshake: an ex-stage event is accepted only in IDLE, in a cycle where
// instr_valid_i=1 and stallreq_ex_i=0. There is no back-pressure on the
// outputs: csr_we_o and jump_en_o are one-cycle strobes that the CSR file
// and fetch unit must consume in the cycle they appear.
//
// Ports:
//   clk_i, rst_ni                 clock, async active-low reset
//   stallreq_ex_i                 ex-stage stall request
//   instr_valid_i/addr_i/data_i   ex-stage instruction valid, PC, encoding
//   exc_illegal_i/ecall_i/ebreak_i  synchronous exception flags
//   mret_i                        MRET decoded in ex
//   csr_mstatus/mie/mip/mtvec/mepc_i  current CSR values
//   stall_o, flush_o, busy_o      pipeline control; busy_o exposes state!=IDLE
//   csr_we_o/waddr_o/wdata_o      CSR write port
//   jump_en_o, jump_addr_o        fetch redirect strobe and target
module trap_ctrl #(
  parameter int unsigned NUM_LOCAL_IRQ = 0,
  parameter bit          VECTORED_EN   = 1'b1,
  parameter bit          EPC_PLUS4     = 1'b0
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        stallreq_ex_i,
  input  logic        instr_valid_i,
  input  logic [31:0] instr_addr_i,
  input  logic [31:0] instr_data_i,
  input  logic        exc_illegal_i,
  input  logic        exc_ecall_i,
  input  logic        exc_ebreak_i,
  input  logic        mret_i,
  input  logic [31:0] csr_mstatus_i,
  input  logic [31:0] csr_mie_i,
  input  logic [31:0] csr_mip_i,
  input  logic [31:0] csr_mtvec_i,
  input  logic [31:0] csr_mepc_i,
  output logic        stall_o,
  output logic        flush_o,
  output logic        busy_o,
  output logic        csr_we_o,
  output logic [11:0] csr_waddr_o,
  output logic [31:0] csr_wdata_o,
  output logic        jump_en_o,
  output logic [31:0] jump_addr_o
);

  localparam logic [11:0] CSR_MSTATUS = 12'h300;
  localparam logic [11:0] CSR_MEPC    = 12'h341;
  localparam logic [11:0] CSR_MCAUSE  = 12'h342;
  localparam logic [11:0] CSR_MTVAL   = 12'h343;

  // Interrupt lines that exist in this configuration: MEI(11), MTI(7),
  // MSI(3) and the local lines 16..16+NUM_LOCAL_IRQ-1.
  localparam logic [31:0] LOCAL_MASK = 32'(((64'd1 << NUM_LOCAL_IRQ) - 64'd1) << 16);
  localparam logic [31:0] IRQ_MASK   = 32'h0000_0888 | LOCAL_MASK;

  typedef enum logic [2:0] {
    S_IDLE,
    S_W_CAUSE,
    S_W_EPC,
    S_W_TVAL,
    S_W_STATUS,
    S_JUMP,
    S_MRET
  } state_t;

  state_t      r_state;
  logic [31:0] r_cause;
  logic [31:0] r_epc;
  logic [31:0] r_tval;
  logic        r_csr_we;
  logic [11:0] r_csr_waddr;
  logic [31:0] r_csr_wdata;
  logic        r_jump_en;
  logic [31:0] r_jump_addr;

  logic [31:0] w_en;
  logic        w_irq_pend;
  logic        w_exc;
  logic        w_idle;
  logic        w_take;
  logic        w_mret;
  logic [4:0]  w_code;
  logic        w_is_irq;
  logic        w_is_ecb;
  logic [31:0] w_tval;
  logic [31:0] w_cause;
  logic [31:0] w_epc;
  logic [31:0] w_mst_trap;
  logic [31:0] w_mst_mret;
  logic        w_vectored;
  logic [31:0] w_target;

  assign w_en       = csr_mip_i & csr_mie_i & IRQ_MASK;
  assign w_irq_pend = (|w_en) & csr_mstatus_i[3];
  assign w_exc      = exc_illegal_i | exc_ecall_i | exc_ebreak_i;
  assign w_idle     = (r_state == S_IDLE);
  assign w_take     = w_idle & instr_valid_i & ~stallreq_ex_i & (w_exc | w_irq_pend);
  // A trap in the same cycle wins; the MRET is then simply not executed.
  assign w_mret     = w_idle & instr_valid_i & ~stallreq_ex_i & mret_i & ~w_take;

  // Cause selection. Exceptions first, then MEI, MSI, MTI, then local lines
  // with the lowest index winning (the loop runs downward so the lowest
  // set bit is the last assignment).
  always_comb begin
    w_code   = 5'd0;
    w_is_irq = 1'b0;
    w_is_ecb = 1'b0;
    w_tval   = 32'd0;
    if (exc_illegal_i) begin
      w_code = 5'd2;
      w_tval = instr_data_i;
    end else if (exc_ecall_i) begin
      w_code   = 5'd11;
      w_is_ecb = 1'b1;
    end else if (exc_ebreak_i) begin
      w_code   = 5'd3;
      w_is_ecb = 1'b1;
      w_tval   = instr_addr_i;
    end else begin
      w_is_irq = 1'b1;
      if (w_en[11]) begin
        w_code = 5'd11;
      end else if (w_en[3]) begin
        w_code = 5'd3;
      end else if (w_en[7]) begin
        w_code = 5'd7;
      end else begin
        for (int k = 15; k >= 0; k--) begin
          if (w_en[16+k]) w_code = 5'(16 + k);
        end
      end
    end
  end

  assign w_cause = {w_is_irq, 26'd0, w_code};
  assign w_epc   = instr_addr_i + ((EPC_PLUS4 && w_is_ecb) ? 32'd4 : 32'd0);

  // mstatus on trap entry: MPIE <= MIE, MIE <= 0, MPP <= M.
  always_comb begin
    w_mst_trap        = csr_mstatus_i;
    w_mst_trap[7]     = csr_mstatus_i[3];
    w_mst_trap[3]     = 1'b0;
    w_mst_trap[12:11] = 2'b11;
  end

  // mstatus on MRET: MIE <= MPIE, MPIE <= 1, MPP stays M (M-only core).
  always_comb begin
    w_mst_mret        = csr_mstatus_i;
    w_mst_mret[3]     = csr_mstatus_i[7];
    w_mst_mret[7]     = 1'b1;
    w_mst_mret[12:11] = 2'b11;
  end

  // Vectoring applies to interrupts only; exceptions always go to base.
  assign w_vectored = VECTORED_EN && (csr_mtvec_i[1:0] == 2'b01) && r_cause[31];
  assign w_target   = {csr_mtvec_i[31:2], 2'b00}
                    + (w_vectored ? {25'd0, r_cause[4:0], 2'b00} : 32'd0);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state     <= S_IDLE;
      r_cause     <= 32'd0;
      r_epc       <= 32'd0;
      r_tval      <= 32'd0;
      r_csr_we    <= 1'b0;
      r_csr_waddr <= 12'd0;
      r_csr_wdata <= 32'd0;
      r_jump_en   <= 1'b0;
      r_jump_addr <= 32'd0;
    end else begin
      // Strobes default low; each state loads the outputs of the next one.
      r_csr_we    <= 1'b0;
      r_csr_waddr <= 12'd0;
      r_csr_wdata <= 32'd0;
      r_jump_en   <= 1'b0;
      r_jump_addr <= 32'd0;
      case (r_state)
        S_IDLE: begin
          if (w_take) begin
            r_state     <= S_W_CAUSE;
            r_cause     <= w_cause;
            r_epc       <= w_epc;
            r_tval      <= w_tval;
            r_csr_we    <= 1'b1;
            r_csr_waddr <= CSR_MCAUSE;
            r_csr_wdata <= w_cause;
          end else if (w_mret) begin
            r_state     <= S_MRET;
            r_csr_we    <= 1'b1;
            r_csr_waddr <= CSR_MSTATUS;
            r_csr_wdata <= w_mst_mret;
            r_jump_en   <= 1'b1;
            r_jump_addr <= csr_mepc_i;
          end
        end
        S_W_CAUSE: begin
          r_state     <= S_W_EPC;
          r_csr_we    <= 1'b1;
          r_csr_waddr <= CSR_MEPC;
          r_csr_wdata <= r_epc;
        end
        S_W_EPC: begin
          r_state     <= S_W_TVAL;
          r_csr_we    <= 1'b1;
          r_csr_waddr <= CSR_MTVAL;
          r_csr_wdata <= r_tval;
        end
        S_W_TVAL: begin
          r_state     <= S_W_STATUS;
          r_csr_we    <= 1'b1;
          r_csr_waddr <= CSR_MSTATUS;
          r_csr_wdata <= w_mst_trap;
        end
        S_W_STATUS: begin
          r_state     <= S_JUMP;
          r_jump_en   <= 1'b1;
          r_jump_addr <= w_target;
        end
        S_JUMP:  r_state <= S_IDLE;
        S_MRET:  r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign busy_o      = ~w_idle;
  // Combinational terms are gated by reset so every output reads 0 in reset.
  assign stall_o     = rst_ni & (stallreq_ex_i | busy_o);
  assign flush_o     = rst_ni & (busy_o | w_take | w_mret);
  assign csr_we_o    = r_csr_we;
  assign csr_waddr_o = r_csr_waddr;
  assign csr_wdata_o = r_csr_wdata;
  assign jump_en_o   = r_jump_en;
  assign jump_addr_o = r_jump_addr;

endmodule

// File: tb/tb_trap_ctrl.sv
// Bench for trap_ctrl. Two instances with different parameter sets share
// the same stimulus: dut0 (4 local IRQs, vectored, mepc=PC) and dut1
// (no local IRQs, direct only, mepc=PC+4 for ecall/ebreak).
module tb_trap_ctrl;

  logic clk = 1'b0;
  logic rst_ni = 1'b0;
  always #5 clk = ~clk;

  logic        stallreq, valid, illegal, ecall, ebreak, mret_in;
  logic [31:0] addr, data, mstatus, mie, mip, mtvec, mepc;

  logic [1:0]  stall_w, flush_w, busy_w, we_w, jen_w;
  logic [11:0] waddr_w [2];
  logic [31:0] wdata_w [2];
  logic [31:0] jaddr_w [2];

  trap_ctrl #(.NUM_LOCAL_IRQ(4), .VECTORED_EN(1'b1), .EPC_PLUS4(1'b0)) u_dut0 (
    .clk_i(clk), .rst_ni(rst_ni), .stallreq_ex_i(stallreq), .instr_valid_i(valid),
    .instr_addr_i(addr), .instr_data_i(data), .exc_illegal_i(illegal),
    .exc_ecall_i(ecall), .exc_ebreak_i(ebreak), .mret_i(mret_in),
    .csr_mstatus_i(mstatus), .csr_mie_i(mie), .csr_mip_i(mip), .csr_mtvec_i(mtvec),
    .csr_mepc_i(mepc), .stall_o(stall_w[0]), .flush_o(flush_w[0]), .busy_o(busy_w[0]),
    .csr_we_o(we_w[0]), .csr_waddr_o(waddr_w[0]), .csr_wdata_o(wdata_w[0]),
    .jump_en_o(jen_w[0]), .jump_addr_o(jaddr_w[0]));

  trap_ctrl #(.NUM_LOCAL_IRQ(0), .VECTORED_EN(1'b0), .EPC_PLUS4(1'b1)) u_dut1 (
    .clk_i(clk), .rst_ni(rst_ni), .stallreq_ex_i(stallreq), .instr_valid_i(valid),
    .instr_addr_i(addr), .instr_data_i(data), .exc_illegal_i(illegal),
    .exc_ecall_i(ecall), .exc_ebreak_i(ebreak), .mret_i(mret_in),
    .csr_mstatus_i(mstatus), .csr_mie_i(mie), .csr_mip_i(mip), .csr_mtvec_i(mtvec),
    .csr_mepc_i(mepc), .stall_o(stall_w[1]), .flush_o(flush_w[1]), .busy_o(busy_w[1]),
    .csr_we_o(we_w[1]), .csr_waddr_o(waddr_w[1]), .csr_wdata_o(wdata_w[1]),
    .jump_en_o(jen_w[1]), .jump_addr_o(jaddr_w[1]));

  // Parameters of each instance, as seen by the reference model.
  int nl_p  [2] = '{4, 0};
  bit vec_p [2] = '{1'b1, 1'b0};
  bit p4_p  [2] = '{1'b0, 1'b1};

  // ---------------- scoreboard state ----------------
  typedef struct {
    int          cyc;
    bit          we;
    logic [11:0] waddr;
    logic [31:0] wdata;
    bit          jmp;
    logic [31:0] jaddr;
  } exp_t;

  exp_t exp_q [2][$];
  int   idle_from [2] = '{0, 0};
  bit   exp_busy [2], exp_stall [2], exp_flush [2];
  bit   in_reset = 1'b1;
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic exp_t mk(int c, bit we, logic [11:0] a, logic [31:0] d,
                              bit j, logic [31:0] ja);
    exp_t e;
    e.cyc = c; e.we = we; e.waddr = a; e.wdata = d; e.jmp = j; e.jaddr = ja;
    return e;
  endfunction

  task automatic chk(input string name, input int i, input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s dut%0d cyc %0d got %08h expected %08h", name, i, cyc, got, exp);
    end
  endtask

  // ---------------- reference model ----------------
  // Decides, from the architectural rules, what an idle controller does
  // with the current inputs.
  function automatic void ref_eval(input int i, output bit take, output bit mret_acc,
                                   output logic [31:0] cause, output logic [31:0] epc,
                                   output logic [31:0] tval);
    logic [31:0] mask, en;
    bit irq, ecb;
    int code;
    mask = 32'h0000_0888;
    for (int k = 0; k < nl_p[i]; k++) mask[16+k] = 1'b1;
    en   = mip & mie & mask;
    irq  = (en != 0) && mstatus[3];
    take = valid && !stallreq && (illegal || ecall || ebreak || irq);
    mret_acc = valid && mret_in && !stallreq && !take;
    ecb  = 1'b0;
    tval = 32'd0;
    cause = 32'd0;
    if (illegal) begin
      cause = 2; tval = data;
    end else if (ecall) begin
      cause = 11; ecb = 1'b1;
    end else if (ebreak) begin
      cause = 3; ecb = 1'b1; tval = addr;
    end else begin
      code = -1;
      if (en[11]) code = 11;
      else if (en[3]) code = 3;
      else if (en[7]) code = 7;
      for (int k = 0; k < nl_p[i]; k++)
        if (code < 0 && en[16+k]) code = 16 + k;
      cause = 32'h8000_0000 | 32'(code);
    end
    epc = addr + ((ecb && p4_p[i]) ? 32'd4 : 32'd0);
  endfunction

  bit          m_idle, m_take, m_mret;
  logic [31:0] m_cause, m_epc, m_tval, m_mst, m_tgt;

  always @(posedge clk) begin
    #3;
    for (int i = 0; i < 2; i++) begin
      if (in_reset) begin
        exp_busy[i] = 1'b0; exp_stall[i] = 1'b0; exp_flush[i] = 1'b0;
      end else begin
        m_idle = (cyc >= idle_from[i]);
        ref_eval(i, m_take, m_mret, m_cause, m_epc, m_tval);
        if (!m_idle) begin m_take = 1'b0; m_mret = 1'b0; end
        exp_busy[i]  = !m_idle;
        exp_stall[i] = stallreq || !m_idle;
        exp_flush[i] = !m_idle || m_take || m_mret;
        if (m_take) begin
          m_mst = (mstatus & ~32'h0000_1888) | (mstatus[3] ? 32'h80 : 32'h0) | 32'h1800;
          m_tgt = {mtvec[31:2], 2'b00};
          if (vec_p[i] && mtvec[1:0] == 2'b01 && m_cause[31])
            m_tgt = m_tgt + ((m_cause & 32'h1F) << 2);
          exp_q[i].push_back(mk(cyc + 1, 1'b1, 12'h342, m_cause, 1'b0, 32'd0));
          exp_q[i].push_back(mk(cyc + 2, 1'b1, 12'h341, m_epc,   1'b0, 32'd0));
          exp_q[i].push_back(mk(cyc + 3, 1'b1, 12'h343, m_tval,  1'b0, 32'd0));
          exp_q[i].push_back(mk(cyc + 4, 1'b1, 12'h300, m_mst,   1'b0, 32'd0));
          exp_q[i].push_back(mk(cyc + 5, 1'b0, 12'h000, 32'd0,   1'b1, m_tgt));
          idle_from[i] = cyc + 6;
        end else if (m_mret) begin
          m_mst = (mstatus & ~32'h0000_1888) | (mstatus[7] ? 32'h8 : 32'h0) | 32'h1880;
          exp_q[i].push_back(mk(cyc + 1, 1'b1, 12'h300, m_mst, 1'b1, mepc));
          idle_from[i] = cyc + 2;
        end
      end
    end
  end

  // ---------------- monitor ----------------
  exp_t e;
  always @(negedge clk) begin
    for (int i = 0; i < 2; i++) begin
      if (in_reset) begin
        chk("reset_ctl", i, {27'd0, stall_w[i], flush_w[i], busy_w[i], we_w[i], jen_w[i]}, 32'd0);
        chk("reset_waddr", i, {20'd0, waddr_w[i]}, 32'd0);
        chk("reset_wdata", i, wdata_w[i], 32'd0);
        chk("reset_jaddr", i, jaddr_w[i], 32'd0);
      end else begin
        while (exp_q[i].size() > 0 && exp_q[i][0].cyc < cyc) begin
          checks++; errors++;
          $display("FAIL missing_event dut%0d cyc %0d got none expected addr %03h at cyc %0d",
                   i, cyc, exp_q[i][0].waddr, exp_q[i][0].cyc);
          void'(exp_q[i].pop_front());
        end
        if (we_w[i] || jen_w[i]) begin
          if (exp_q[i].size() == 0 || exp_q[i][0].cyc != cyc) begin
            checks++; errors++;
            $display("FAIL unexpected_event dut%0d cyc %0d got we %0d addr %03h jump %0d expected none",
                     i, cyc, we_w[i], waddr_w[i], jen_w[i]);
          end else begin
            e = exp_q[i].pop_front();
            chk("csr_we", i, {31'd0, we_w[i]}, {31'd0, e.we});
            chk("jump_en", i, {31'd0, jen_w[i]}, {31'd0, e.jmp});
            if (e.we) begin
              chk("csr_waddr", i, {20'd0, waddr_w[i]}, {20'd0, e.waddr});
              chk("csr_wdata", i, wdata_w[i], e.wdata);
            end
            if (e.jmp) chk("jump_addr", i, jaddr_w[i], e.jaddr);
          end
        end
        chk("busy", i, {31'd0, busy_w[i]}, {31'd0, exp_busy[i]});
        chk("stall", i, {31'd0, stall_w[i]}, {31'd0, exp_stall[i]});
        chk("flush", i, {31'd0, flush_w[i]}, {31'd0, exp_flush[i]});
      end
    end
  end

  // ---------------- driver ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_ev();
    valid = 0; stallreq = 0; illegal = 0; ecall = 0; ebreak = 0; mret_in = 0;
  endtask

  function automatic bit both_idle();
    return (cyc >= idle_from[0]) && (cyc >= idle_from[1]);
  endfunction

  task automatic wait_idle();
    int n = 0;
    while (!both_idle()) begin
      tick();
      n++;
      if (n > 50) begin
        checks++; errors++;
        $display("FAIL idle_timeout cyc %0d got busy expected idle within 50 cycles", cyc);
        break;
      end
    end
  endtask

  task automatic set_csr(input logic [31:0] st, input logic [31:0] ie, input logic [31:0] ip,
                         input logic [31:0] tv, input logic [31:0] ep);
    mstatus = st; mie = ie; mip = ip; mtvec = tv; mepc = ep;
  endtask

  // One-cycle event, then wait until both instances are idle again.
  task automatic fire(input logic [31:0] a, input logic [31:0] d, input bit il,
                      input bit ec, input bit eb, input bit mr, input bit st);
    tick();
    valid = 1; addr = a; data = d; illegal = il; ecall = ec; ebreak = eb;
    mret_in = mr; stallreq = st;
    tick();
    clear_ev();
    wait_idle();
  endtask

  initial begin
    clear_ev();
    addr = 0; data = 0;
    set_csr(32'h0, 32'h0, 32'h0, 32'h0, 32'h0);
    repeat (4) tick();
    rst_ni = 1'b1; in_reset = 1'b0;
    tick();

    // ecall, direct mtvec
    set_csr(32'h8, 32'h0, 32'h0, 32'h2000, 32'h0);
    fire(32'h100, 32'h0000_0073, 0, 1, 0, 0, 0);
    // MTI with vectored mtvec (dut1 ignores vectoring)
    set_csr(32'h8, 32'h80, 32'h80, 32'h2001, 32'h0);
    fire(32'h200, 32'h13, 0, 0, 0, 0, 0);
    // mixed standard + local lines, then local only
    set_csr(32'h8, 32'h000A_0088, 32'h000A_0088, 32'h2001, 32'h0);
    fire(32'h300, 32'h13, 0, 0, 0, 0, 0);
    set_csr(32'h8, 32'h000A_0088, 32'h000A_0000, 32'h2001, 32'h0);
    fire(32'h304, 32'h13, 0, 0, 0, 0, 0);
    // illegal beats a pending MTI
    set_csr(32'h8, 32'h80, 32'h80, 32'h2000, 32'h0);
    fire(32'h40, 32'hFFFF_FFFF, 1, 0, 0, 0, 0);
    // MRET with interrupts masked, then MIE set so MTI is retaken
    set_csr(32'h1880, 32'h80, 32'h80, 32'h2000, 32'h104);
    fire(32'h48, 32'h3020_0073, 0, 0, 0, 1, 0);
    set_csr(32'h8, 32'h80, 32'h80, 32'h2000, 32'h104);
    fire(32'h104, 32'h13, 0, 0, 0, 0, 0);
    // ecall and MRET together: trap wins
    set_csr(32'h1880, 32'h0, 32'h0, 32'h3000, 32'h900);
    fire(32'h500, 32'h73, 0, 1, 0, 1, 0);
    // ebreak: mtval = PC
    set_csr(32'h8, 32'h0, 32'h0, 32'h3000, 32'h0);
    fire(32'h600, 32'h0010_0073, 0, 0, 1, 0, 0);
    // stalled ecall is not taken
    fire(32'h610, 32'h73, 0, 1, 0, 0, 1);
    // all interrupts pending but mstatus.MIE = 0: never taken
    set_csr(32'h1880, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h2000, 32'h0);
    for (int n = 0; n < 8; n++) begin
      tick(); valid = 1; addr = $urandom & ~32'h3;
    end
    tick(); clear_ev(); wait_idle();

    // reset in the middle of a trap sequence
    set_csr(32'h8, 32'h0, 32'h0, 32'h2000, 32'h0);
    tick(); valid = 1; ecall = 1; addr = 32'h700;
    tick(); clear_ev();
    tick();
    rst_ni = 1'b0; in_reset = 1'b1;
    for (int i = 0; i < 2; i++) begin exp_q[i].delete(); idle_from[i] = 0; end
    repeat (3) tick();
    rst_ni = 1'b1; in_reset = 1'b0;
    fire(32'h800, 32'h73, 0, 1, 0, 0, 0);

    // randomized traffic
    for (int n = 0; n < 1500; n++) begin
      tick();
      if (both_idle() && $urandom_range(0, 3) == 0) begin
        mstatus = $urandom;
        mie     = $urandom;
        mip     = ($urandom_range(0, 1) == 1) ? ($urandom & 32'h000F_0888) : $urandom;
        if ($urandom_range(0, 3) == 0) mip = 32'h0;
        mtvec   = ($urandom_range(0, 7) == 0) ? (32'hFFFF_FFC0 | 32'($urandom_range(0, 3))) : $urandom;
        mepc    = $urandom;
      end
      valid    = ($urandom_range(0, 9) < 7);
      stallreq = ($urandom_range(0, 9) < 2);
      illegal  = ($urandom_range(0, 19) == 0);
      ecall    = ($urandom_range(0, 19) == 0);
      ebreak   = ($urandom_range(0, 19) == 0);
      mret_in  = ($urandom_range(0, 7) == 0);
      addr     = $urandom & ~32'h3;
      data     = $urandom;
    end
    tick(); clear_ev();
    wait_idle();
    repeat (3) tick();

    for (int i = 0; i < 2; i++) chk("leftover_expected", i, exp_q[i].size(), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
